p_arb: RTL and testbench

P_ARB -- requirements
Module: p_arb

---
 rtl/p_pkg.sv | 14 +
 rtl/p.sv | 30 +++
 rtl/p_arb.sv | 124 ++++++++++++
 tb/tb_p_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/p_pkg.sv
// Shared types and helpers for the round-robin unary-admission arbiter.
package p_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p.sv
// Unary admission checker: accepts 0..01..1 codes, and optionally their complements.
module p #(
    parameter int W                     = 16,
    parameter int P_ADMIT_COMPLIMENT_EN = 0
) (
    input  logic [W-1:0] x_i,
    output logic         is_unary_o
);

    localparam logic EN = (P_ADMIT_COMPLIMENT_EN != 0);

    logic [W-1:0] xp_s;
    logic [W-1:0] inc_s;
    logic         onehot_s;

    // Fold the complemented form onto the plain form, then test x'+1 for a single set bit.
    always_comb begin
        xp_s     = x_i ^ {W{EN & x_i[W-1]}};
        inc_s    = xp_s + W'(1);
        onehot_s = (inc_s != '0) && ((inc_s & (inc_s - W'(1))) == '0);
        if ((x_i == '0) || (x_i == '1)) begin
            is_unary_o = 1'b0;
        end else if (!EN && x_i[W-1]) begin
            is_unary_o = 1'b0;
        end else begin
            is_unary_o = onehot_s;
        end
    end

endmodule

// File: rtl/p_arb.sv
// N-way round-robin arbiter feeding a one-deep response register with unary admission and saturating statistics.
module p_arb
    import p_pkg::*;
#(
    parameter int  W                     = 16,
    parameter int  N                     = 4,
    parameter int  P_ADMIT_COMPLIMENT_EN = 0,
    parameter int  CNT_W                 = 16,
    localparam int IDW                   = idw(N)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [N-1:0]     i_req_vld,
    input  logic [N*W-1:0]   i_req_x,
    output logic [N-1:0]     o_req_rdy,
    output logic             o_rsp_vld,
    output logic [IDW-1:0]   o_rsp_id,
    output logic [W-1:0]     o_rsp_x,
    output logic             o_rsp_is_unary,
    input  logic             i_rsp_rdy,
    input  logic             i_cnt_clr,
    output logic [CNT_W-1:0] o_cnt_admit,
    output logic [CNT_W-1:0] o_cnt_reject
);

    state_e            state_q;
    logic [IDW-1:0]    rr_ptr_q;
    logic [IDW-1:0]    rr_ptr_d;
    logic [IDW-1:0]    rsp_id_q;
    logic [W-1:0]      rsp_x_q;
    logic              rsp_unary_q;
    logic [CNT_W-1:0]  cnt_admit_q;
    logic [CNT_W-1:0]  cnt_reject_q;

    logic              accept_s;
    logic              hs_s;
    logic              gnt_any_s;
    logic [N-1:0]      gnt_s;
    logic [IDW-1:0]    gnt_id_s;
    logic [W-1:0]      gnt_x_s;
    logic              gnt_unary_s;

    // Round-robin select starting at rr_ptr; grants are suppressed while reset is asserted.
    always_comb begin : rr_sel
        logic [IDW-1:0] idx;
        idx       = '0;
        accept_s  = (state_q == EMPTY) || i_rsp_rdy;
        hs_s      = (state_q == FULL) && i_rsp_rdy;
        gnt_s     = '0;
        gnt_id_s  = '0;
        gnt_any_s = 1'b0;
        gnt_x_s   = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(rr_ptr_q) + i) % N);
            if (arst_n && accept_s && !gnt_any_s && i_req_vld[idx]) begin
                gnt_any_s  = 1'b1;
                gnt_s[idx] = 1'b1;
                gnt_id_s   = idx;
            end else begin
                gnt_any_s  = gnt_any_s;
            end
        end
        for (int k = 0; k < N; k++) begin
            gnt_x_s = gnt_x_s | ({W{gnt_s[k]}} & i_req_x[k*W +: W]);
        end
        if (!gnt_any_s) begin
            rr_ptr_d = rr_ptr_q;
        end else if (gnt_id_s == IDW'(N - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = gnt_id_s + IDW'(1);
        end
    end

    p #(
        .W                     (W),
        .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
    ) u_p (
        .x_i        (gnt_x_s),
        .is_unary_o (gnt_unary_s)
    );

    // Response FSM, captured response, pointer and statistics; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= EMPTY;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_x_q      <= '0;
            rsp_unary_q  <= 1'b0;
            cnt_admit_q  <= '0;
            cnt_reject_q <= '0;
        end else begin
            case (state_q)
                EMPTY:   state_q <= gnt_any_s ? FULL : EMPTY;
                FULL:    state_q <= (gnt_any_s || !i_rsp_rdy) ? FULL : EMPTY;
                default: state_q <= EMPTY;
            endcase
            if (gnt_any_s) begin
                rsp_id_q    <= gnt_id_s;
                rsp_x_q     <= gnt_x_s;
                rsp_unary_q <= gnt_unary_s;
            end
            rr_ptr_q <= rr_ptr_d;
            if (i_cnt_clr) begin
                cnt_admit_q  <= '0;
                cnt_reject_q <= '0;
            end else if (hs_s && rsp_unary_q) begin
                if (cnt_admit_q != '1) cnt_admit_q <= cnt_admit_q + CNT_W'(1);
            end else if (hs_s) begin
                if (cnt_reject_q != '1) cnt_reject_q <= cnt_reject_q + CNT_W'(1);
            end
        end
    end

    assign o_req_rdy      = gnt_s;
    assign o_rsp_vld      = (state_q == FULL);
    assign o_rsp_id       = rsp_id_q;
    assign o_rsp_x        = rsp_x_q;
    assign o_rsp_is_unary = rsp_unary_q;
    assign o_cnt_admit    = cnt_admit_q;
    assign o_cnt_reject   = cnt_reject_q;

endmodule

// File: tb/tb_p_arb.sv
// Scoreboard bench: two arbiters (plain admission, 16-bit counters / complement admission, 2-bit counters) share one stimulus.
module tb_p_arb;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk;
    logic          arst_n;
    logic [N-1:0]  i_req_vld;
    logic [N*W-1:0] i_req_x;
    logic          i_rsp_rdy;
    logic          i_cnt_clr;

    logic [N-1:0]  rdy_a, rdy_b;
    logic          vld_a, vld_b;
    logic [1:0]    id_a, id_b;
    logic [W-1:0]  x_a, x_b;
    logic          un_a, un_b;
    logic [15:0]   ca_a, cr_a;
    logic [1:0]    ca_b, cr_b;

    p_arb #(.W(W), .N(N), .P_ADMIT_COMPLIMENT_EN(0), .CNT_W(16)) u_dut_a (
        .clk(clk), .arst_n(arst_n), .i_req_vld(i_req_vld), .i_req_x(i_req_x),
        .o_req_rdy(rdy_a), .o_rsp_vld(vld_a), .o_rsp_id(id_a), .o_rsp_x(x_a),
        .o_rsp_is_unary(un_a), .i_rsp_rdy(i_rsp_rdy), .i_cnt_clr(i_cnt_clr),
        .o_cnt_admit(ca_a), .o_cnt_reject(cr_a)
    );

    p_arb #(.W(W), .N(N), .P_ADMIT_COMPLIMENT_EN(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .arst_n(arst_n), .i_req_vld(i_req_vld), .i_req_x(i_req_x),
        .o_req_rdy(rdy_b), .o_rsp_vld(vld_b), .o_rsp_id(id_b), .o_rsp_x(x_b),
        .o_rsp_is_unary(un_b), .i_rsp_rdy(i_rsp_rdy), .i_cnt_clr(i_cnt_clr),
        .o_cnt_admit(ca_b), .o_cnt_reject(cr_b)
    );

    typedef struct {
        int          id;
        logic [15:0] x;
        bit          u0;
        bit          u1;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    bit   m_full;
    int   m_ptr;
    int   m_ca0, m_cr0, m_ca1, m_cr1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference admission: x' must equal 2^k-1 for some 1 <= k <= W-1.
    function automatic bit ref_unary(input logic [15:0] x, input bit en);
        logic [15:0] xp;
        if (!en && x[15]) return 1'b0;
        xp = (en && x[15]) ? ~x : x;
        for (int k = 1; k < 16; k++) begin
            if (xp == 16'((32'd1 << k) - 32'd1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v >= maxv) ? maxv : v + 1;
    endfunction

    function automatic logic [15:0] pick_x();
        int k;
        logic [15:0] u;
        k = $urandom_range(0, 16);
        u = 16'((32'd1 << k) - 32'd1);
        case ($urandom_range(0, 2))
            0:       return u;
            1:       return ~u;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock cycle of stimulus; entered and left 2 time units after a rising edge.
    task automatic cyc(input logic [3:0] vld, input logic [63:0] xs, input logic rdy, input logic clr);
        int          g;
        bit          hs;
        logic [3:0]  exp_rdy;
        logic [15:0] xg;
        i_req_vld = vld;
        i_req_x   = xs;
        i_rsp_rdy = rdy;
        i_cnt_clr = clr;
        #1;
        chk("rsp_vld_a", 64'(vld_a), 64'(m_full));
        chk("rsp_vld_b", 64'(vld_b), 64'(m_full));
        chk("cnt_admit_a", 64'(ca_a), 64'(m_ca0));
        chk("cnt_reject_a", 64'(cr_a), 64'(m_cr0));
        chk("cnt_admit_b", 64'(ca_b), 64'(m_ca1));
        chk("cnt_reject_b", 64'(cr_b), 64'(m_cr1));
        hs = m_full && rdy;
        g  = -1;
        if (!m_full || rdy) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && vld[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        chk("req_rdy_a", 64'(rdy_a), 64'(exp_rdy));
        chk("req_rdy_b", 64'(rdy_b), 64'(exp_rdy));
        if (clr) begin
            m_ca0 = 0; m_cr0 = 0; m_ca1 = 0; m_cr1 = 0;
        end else if (hs && exp_q.size() > 0) begin
            if (exp_q[0].u0) m_ca0 = sat_inc(m_ca0, 65535); else m_cr0 = sat_inc(m_cr0, 65535);
            if (exp_q[0].u1) m_ca1 = sat_inc(m_ca1, 3);     else m_cr1 = sat_inc(m_cr1, 3);
        end
        if (g >= 0) begin
            xg = xs[g*16 +: 16];
            exp_q.push_back('{id: g, x: xg, u0: ref_unary(xg, 1'b0), u1: ref_unary(xg, 1'b1)});
            m_ptr = (g + 1) % N;
        end
        m_full = (g >= 0) || (m_full && !rdy);
        @(posedge clk);
        #2;
    endtask

    // Reset for one clock edge with requests pending; everything must read idle while asserted.
    task automatic do_reset();
        arst_n    = 1'b0;
        i_req_vld = 4'b1111;
        i_req_x   = 64'h00FF_00FF_00FF_00FF;
        i_rsp_rdy = 1'b1;
        i_cnt_clr = 1'b0;
        #1;
        chk("rst_rsp_vld_a", 64'(vld_a), 64'd0);
        chk("rst_rsp_vld_b", 64'(vld_b), 64'd0);
        chk("rst_req_rdy_a", 64'(rdy_a), 64'd0);
        chk("rst_req_rdy_b", 64'(rdy_b), 64'd0);
        chk("rst_rsp_id", 64'(id_a), 64'd0);
        chk("rst_rsp_x", 64'(x_a), 64'd0);
        chk("rst_unary", 64'(un_a), 64'd0);
        chk("rst_cnt_a", 64'({ca_a, cr_a}), 64'd0);
        chk("rst_cnt_b", 64'({ca_b, cr_b}), 64'd0);
        exp_q.delete();
        m_full = 1'b0; m_ptr = 0;
        m_ca0 = 0; m_cr0 = 0; m_ca1 = 0; m_cr1 = 0;
        @(posedge clk);
        #2;
        arst_n = 1'b1;
    endtask

    // Monitor: every presented response must match the scoreboard head; it leaves the queue on handshake.
    always @(negedge clk) begin
        if (arst_n && vld_a) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id %0d x %0h expected no response at %0t", id_a, x_a, $time);
            end else begin
                chk("rsp_id_a", 64'(id_a), 64'(exp_q[0].id));
                chk("rsp_x_a", 64'(x_a), 64'(exp_q[0].x));
                chk("rsp_unary_a", 64'(un_a), 64'(exp_q[0].u0));
                chk("rsp_id_b", 64'(id_b), 64'(exp_q[0].id));
                chk("rsp_x_b", 64'(x_b), 64'(exp_q[0].x));
                chk("rsp_unary_b", 64'(un_b), 64'(exp_q[0].u1));
                if (i_rsp_rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] xs;
        arst_n = 1'b0;
        i_req_vld = '0; i_req_x = '0; i_rsp_rdy = 1'b0; i_cnt_clr = 1'b0;
        m_full = 1'b0; m_ptr = 0;
        m_ca0 = 0; m_cr0 = 0; m_ca1 = 0; m_cr1 = 0;
        @(posedge clk);
        #2;
        do_reset();

        // Single admitted request, then let the counter update be seen.
        cyc(4'b0001, 64'h0000_0000_0000_00FF, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);

        // All requesters continuously valid: rotating grants at full throughput.
        for (int i = 0; i < 6; i++) cyc(4'b1111, 64'h0007_003F_0001_7FFF, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);

        // Boundary vectors on requester 0 after a counter clear.
        cyc(4'b0000, 64'h0, 1'b1, 1'b1);
        cyc(4'b0001, 64'h0000, 1'b1, 1'b0);
        cyc(4'b0001, 64'hFFFF, 1'b1, 1'b0);
        cyc(4'b0001, 64'hFF00, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);

        // Back-pressure for five cycles while full.
        cyc(4'b0010, 64'h0000_0000_0FFF_0000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(4'b1111, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);

        // Saturation of the 2-bit counters, then clear coinciding with a handshake.
        cyc(4'b0000, 64'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cyc(4'b0001, 64'h0003, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);
        cyc(4'b0001, 64'h0003, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b1);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < N; r++) xs[r*16 +: 16] = pick_x();
            cyc(4'($urandom_range(0, 15)), xs, ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
        end

        // Reset while full, then the lowest valid index must win.
        cyc(4'b1111, 64'h00FF_00FF_00FF_00FF, 1'b1, 1'b0);
        cyc(4'b1111, 64'h00FF_00FF_00FF_00FF, 1'b0, 1'b0);
        do_reset();
        cyc(4'b1110, 64'h0001_0003_0007_000F, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);
        cyc(4'b0000, 64'h0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
